i2c_slave_regs: RTL and testbench



---
 rtl/i2c_slave_regs.sv | 185 ++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// I2C target exposing NUM_REGS 8-bit registers behind an auto-incrementing byte pointer.
// SCL/SDA are synchronized and edge-detected in the clk domain; SDA is only ever pulled low.
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h42,
   parameter int         NUM_REGS    = 16,
   parameter int         SYNC_STAGES = 2,
   localparam int        AW          = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl,
   input  logic          sda_in,
   output logic          sda_oe,
   output logic          wr_valid,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   input  logic [AW-1:0] host_raddr,
   output logic [7:0]    host_rdata,
   output logic          busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_prev, sda_prev;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_cond, stop_cond;

   state_t        state;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          byte_done;
   logic          rd_nack;
   logic [AW-1:0] ptr;
   logic [7:0]    regs [NUM_REGS];
   logic          addr_match;

   // Input synchronizers plus one history stage; preset high to look like an idle bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s      = scl_sync[SYNC_STAGES-1];
   assign sda_s      = sda_sync[SYNC_STAGES-1];
   assign scl_rise   = scl_s & ~scl_prev;
   assign scl_fall   = ~scl_s & scl_prev;
   assign start_cond = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda_s;

   assign addr_match = (shift[7:1] == SLAVE_ADDR);
   assign host_rdata = regs[host_raddr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         byte_done <= 1'b0;
         rd_nack   <= 1'b0;
         ptr       <= '0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_valid <= 1'b0;
         if (start_cond) begin
            state     <= ADDR;
            shift     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            sda_oe    <= 1'b0;
         end else if (stop_cond) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
         end else if (scl_rise) begin
            if (state inside {ADDR, PTR, WR_DATA, RD_DATA}) begin
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end
            if (state inside {ADDR, PTR, WR_DATA}) shift <= {shift[6:0], sda_s};
            if (state == RD_ACK) rd_nack <= sda_s;
         end else if (scl_fall) begin
            case (state)
               ADDR: begin
                  if (byte_done) begin
                     byte_done <= 1'b0;
                     bit_cnt   <= '0;
                     if (addr_match) begin
                        busy   <= 1'b1;
                        sda_oe <= 1'b1;
                        state  <= ADDR_ACK;
                     end else begin
                        state  <= IGNORE;
                     end
                  end
               end
               ADDR_ACK: begin
                  // shift still holds the address byte, so bit 0 is R/W
                  if (!shift[0]) begin
                     sda_oe <= 1'b0;
                     state  <= PTR;
                  end else begin
                     shift  <= regs[ptr];
                     sda_oe <= ~regs[ptr][7];
                     state  <= RD_DATA;
                  end
               end
               PTR: begin
                  if (byte_done) begin
                     byte_done <= 1'b0;
                     bit_cnt   <= '0;
                     ptr       <= shift[AW-1:0];
                     sda_oe    <= 1'b1;
                     state     <= PTR_ACK;
                  end
               end
               PTR_ACK: begin
                  sda_oe <= 1'b0;
                  state  <= WR_DATA;
               end
               WR_DATA: begin
                  if (byte_done) begin
                     byte_done  <= 1'b0;
                     bit_cnt    <= '0;
                     regs[ptr]  <= shift;
                     wr_valid   <= 1'b1;
                     wr_addr    <= ptr;
                     wr_data    <= shift;
                     ptr        <= ptr + AW'(1);
                     sda_oe     <= 1'b1;
                     state      <= WR_ACK;
                  end
               end
               WR_ACK: begin
                  sda_oe <= 1'b0;
                  state  <= WR_DATA;
               end
               RD_DATA: begin
                  if (byte_done) begin
                     byte_done <= 1'b0;
                     bit_cnt   <= '0;
                     sda_oe    <= 1'b0;
                     ptr       <= ptr + AW'(1);
                     state     <= RD_ACK;
                  end else begin
                     shift  <= {shift[6:0], 1'b0};
                     sda_oe <= ~shift[6];
                  end
               end
               RD_ACK: begin
                  if (!rd_nack) begin
                     shift  <= regs[ptr];
                     sda_oe <= ~regs[ptr][7];
                     state  <= RD_DATA;
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= IGNORE;
                  end
               end
               IGNORE:  sda_oe <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed plus randomized bus transactions against i2c_slave_regs, checked by a register-file model.
module tb_i2c_slave_regs;

   localparam int NREGS = 16;
   localparam int Q     = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_line;
   logic       sda_oe, wr_valid, busy;
   logic [3:0] wr_addr;
   logic [3:0] host_raddr = 4'd0;
   logic [7:0] wr_data, host_rdata;

   assign sda_line = m_sda & ~sda_oe;

   i2c_slave_regs #(.SLAVE_ADDR(7'h42), .NUM_REGS(NREGS), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .host_raddr(host_raddr),
      .host_rdata(host_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  model_regs [NREGS];
   int          model_ptr;
   logic [7:0]  wq [$];
   logic [11:0] exp_wr [$];
   logic [11:0] obs_wr [$];
   int          obs_idx = 0;
   int          oe_cnt = 0;
   int          busy_cnt = 0;

   always @(negedge clk) begin
      if (wr_valid) obs_wr.push_back({wr_addr, wr_data});
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clock_bit(input logic drive, output logic seen);
      m_sda = drive;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      seen = sda_line;
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic bus_start();
      m_sda = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(2*Q);
      m_sda = 1'b0;
      tick(2*Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0;
      tick(Q);
      scl = 1'b1;
      tick(2*Q);
      m_sda = 1'b1;
      tick(2*Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic master_nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         b[i] = s;
      end
      clock_bit(master_nack, s);
   endtask

   task automatic write_txn(input logic [7:0] ptr_byte);
      logic ack;
      bus_start();
      send_byte(8'h84, ack);
      check("wr_addr_ack", 32'(ack), 32'd0);
      check("busy_set", 32'(busy), 32'd1);
      send_byte(ptr_byte, ack);
      check("wr_ptr_ack", 32'(ack), 32'd0);
      model_ptr = int'(ptr_byte) % NREGS;
      foreach (wq[i]) begin
         send_byte(wq[i], ack);
         check("wr_data_ack", 32'(ack), 32'd0);
         model_regs[model_ptr] = wq[i];
         exp_wr.push_back({4'(model_ptr), wq[i]});
         model_ptr = (model_ptr + 1) % NREGS;
      end
      bus_stop();
      check("wr_busy_clear", 32'(busy), 32'd0);
      wq.delete();
   endtask

   // set_ptr < 0 reads from wherever the pointer was left
   task automatic read_txn(input int set_ptr, input int n);
      logic ack;
      logic [7:0] d;
      bus_start();
      if (set_ptr >= 0) begin
         send_byte(8'h84, ack);
         check("rd_waddr_ack", 32'(ack), 32'd0);
         send_byte(8'(set_ptr), ack);
         check("rd_ptr_ack", 32'(ack), 32'd0);
         model_ptr = set_ptr % NREGS;
         bus_start();
      end
      send_byte(8'h85, ack);
      check("rd_addr_ack", 32'(ack), 32'd0);
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, d);
         check("rd_data", 32'(d), 32'(model_regs[model_ptr]));
         model_ptr = (model_ptr + 1) % NREGS;
      end
      tick(2);
      check("rd_release", 32'(sda_oe), 32'd0);
      bus_stop();
      check("rd_busy_clear", 32'(busy), 32'd0);
   endtask

   task automatic check_writes();
      check("wr_count", 32'(obs_wr.size() - obs_idx), 32'(exp_wr.size()));
      foreach (exp_wr[i])
         if (obs_idx + i < obs_wr.size()) check("wr_event", 32'(obs_wr[obs_idx + i]), 32'(exp_wr[i]));
      obs_idx = obs_wr.size();
      exp_wr.delete();
   endtask

   task automatic check_all_regs(input string tag);
      for (int a = 0; a < NREGS; a++) begin
         host_raddr = 4'(a);
         #1;
         check(tag, 32'(host_rdata), 32'(model_regs[a]));
      end
   endtask

   task automatic check_reg(input string tag, input int a, input logic [7:0] exp);
      host_raddr = 4'(a);
      #1;
      check(tag, 32'(host_rdata), 32'(exp));
   endtask

   initial begin
      logic ack, s;
      int oe0, busy0, p, n;

      for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
      model_ptr = 0;

      tick(3);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick(3);
      check_all_regs("rst_regs");

      // Directed two-register write and its read-back
      wq = '{8'hA5, 8'h5A};
      write_txn(8'h03);
      check_writes();
      check_reg("hr3", 3, 8'hA5);
      check_reg("hr4", 4, 8'h5A);
      read_txn(3, 2);

      // Address 0x43 must never be acknowledged or driven
      oe0 = oe_cnt;
      busy0 = busy_cnt;
      bus_start();
      send_byte(8'h86, ack);
      check("bad_addr_nack", 32'(ack), 32'd1);
      send_byte(8'h03, ack);
      check("bad_ptr_nack", 32'(ack), 32'd1);
      send_byte(8'h77, ack);
      bus_stop();
      check("bad_addr_oe", 32'(oe_cnt - oe0), 32'd0);
      check("bad_addr_busy", 32'(busy_cnt - busy0), 32'd0);
      check_writes();

      // Pointer wrap and out-of-range pointer
      wq = '{8'h11, 8'h22};
      write_txn(8'h0F);
      check_writes();
      check_reg("wrap_r15", 15, 8'h11);
      check_reg("wrap_r0", 0, 8'h22);
      wq = '{8'($urandom)};
      write_txn(8'h13);
      check_writes();
      check_reg("oor_r3", 3, model_regs[3]);

      // Pointer persists into a later read-only transaction
      write_txn(8'(5));
      check_writes();
      read_txn(-1, 2);

      // Randomized write / read-back
      repeat (4) begin
         p = int'($urandom_range(0, 255));
         n = int'($urandom_range(1, 4));
         for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
         write_txn(8'(p));
         check_writes();
         read_txn(p, n);
      end
      check_all_regs("rand_regs");

      // STOP after four data bits abandons the byte
      bus_start();
      send_byte(8'h84, ack);
      check("abort_addr_ack", 32'(ack), 32'd0);
      send_byte(8'h07, ack);
      check("abort_ptr_ack", 32'(ack), 32'd0);
      model_ptr = 7;
      for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
      bus_stop();
      check("abort_busy", 32'(busy), 32'd0);
      check_writes();
      check_all_regs("abort_regs");
      wq = '{8'($urandom), 8'($urandom)};
      write_txn(8'h0A);
      check_writes();
      read_txn(10, 2);

      // Reset asserted while the target drives a read byte
      wq = '{8'h00};
      write_txn(8'h09);
      check_writes();
      bus_start();
      send_byte(8'h84, ack);
      send_byte(8'h09, ack);
      bus_start();
      send_byte(8'h85, ack);
      check("rr_addr_ack", 32'(ack), 32'd0);
      for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
      check("rr_driving", 32'(sda_oe), 32'd1);
      rst = 1'b1;
      #1;
      check("rr_sda_oe", 32'(sda_oe), 32'd0);
      check("rr_busy", 32'(busy), 32'd0);
      for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
      model_ptr = 0;
      check_all_regs("rr_regs");
      tick(2);
      rst = 1'b0;
      tick(2);
      bus_stop();
      wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
      write_txn(8'h0E);
      check_writes();
      read_txn(14, 3);
      check_all_regs("final_regs");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
